// File: rtl/alu_pkg.sv
// Shared definitions for the 8080 ALU sequencer: op codes, FSM states, flag bit positions.
// The optional auxiliary-carry feature is selected with the ALU_SEQ_AC_EN macro.
package alu_pkg;

   localparam logic [3:0] INC                = 4'd0;
   localparam logic [3:0] DEC                = 4'd1;
   localparam logic [3:0] ADD                = 4'd2;
   localparam logic [3:0] ADD_CARRY          = 4'd3;
   localparam logic [3:0] SUB                = 4'd4;
   localparam logic [3:0] SUB_BORROW         = 4'd5;
   localparam logic [3:0] AND                = 4'd6;
   localparam logic [3:0] XOR                = 4'd7;
   localparam logic [3:0] OR                 = 4'd8;
   localparam logic [3:0] COMPLEMENT         = 4'd9;
   localparam logic [3:0] ROTATE_LEFT        = 4'd10;
   localparam logic [3:0] ROTATE_RIGHT       = 4'd11;
   localparam logic [3:0] ROTATE_LEFT_CARRY  = 4'd12;
   localparam logic [3:0] ROTATE_RIGHT_CARRY = 4'd13;
   localparam logic [3:0] CMC                = 4'd14;
   localparam logic [3:0] STC                = 4'd15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXEC_LO = 2'd1,
      EXEC_HI = 2'd2,
      RESP    = 2'd3
   } alu_seq_state_t;

   // Flag vector layout is {S,Z,AC,P,CY}.
   localparam int unsigned FLG_S  = 4;
   localparam int unsigned FLG_Z  = 3;
   localparam int unsigned FLG_AC = 2;
   localparam int unsigned FLG_P  = 1;
   localparam int unsigned FLG_CY = 0;

   function automatic logic uses_cy(input logic [3:0] op);
      return op inside {ADD_CARRY, SUB_BORROW, ROTATE_LEFT_CARRY, ROTATE_RIGHT_CARRY, CMC};
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Decoder-side request/response channels of the ALU sequencer.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// the sender holds valid and its payload stable until that edge, and ready may depend on state only.
interface alu_seq_if;
   import alu_pkg::*;

   logic        req_valid_i;
   logic        req_ready_o;
   logic [3:0]  req_op_i;
   logic        req_dad_i;
   logic        req_cmp_i;
   logic [15:0] req_a_i;
   logic [15:0] req_b_i;

   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [15:0] rsp_dat_o;
   logic        rsp_wb_o;

   modport master (
      output req_valid_i, req_op_i, req_dad_i, req_cmp_i, req_a_i, req_b_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_wb_o
   );

   modport slave (
      input  req_valid_i, req_op_i, req_dad_i, req_cmp_i, req_a_i, req_b_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_wb_o
   );

endinterface

// File: rtl/alu_seq_flags.sv
// Architectural flag register {S,Z,AC,P,CY}: per-op update mask, POP PSW load port.
// With ALU_SEQ_AC_EN defined, AC is derived here from the operand low nibbles; otherwise AC stays 0.
module alu_seq_flags
   import alu_pkg::*;
#(
   parameter logic [4:0] FLAGS_RST = 5'b00000
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       load_i,
   input  logic [4:0] load_dat_i,
   input  logic       commit_i,
   input  logic [3:0] op_i,
   input  logic       dad_i,
   input  logic [3:0] alu_flag_i,
`ifdef ALU_SEQ_AC_EN
   input  logic [3:0] a_nib_i,
   input  logic [3:0] b_nib_i,
   input  logic       cin_i,
`endif
   output logic [4:0] flags_o
);

`ifdef ALU_SEQ_AC_EN
   localparam logic [4:0] RST_VAL = FLAGS_RST;
`else
   localparam logic [4:0] RST_VAL = FLAGS_RST & 5'b11011;
`endif

   logic [4:0] flags_q, flags_d;
   logic       upd_szp, upd_cy, upd_ac, clr_logic;
   logic       ac_new;

   always_comb begin
      upd_szp   = 1'b0;
      upd_cy    = 1'b0;
      upd_ac    = 1'b0;
      clr_logic = 1'b0;
      if (dad_i) begin
         upd_cy = 1'b1;
      end else begin
         case (op_i)
            ADD, ADD_CARRY, SUB, SUB_BORROW: begin
               upd_szp = 1'b1;
               upd_cy  = 1'b1;
               upd_ac  = 1'b1;
            end
            INC, DEC: begin
               upd_szp = 1'b1;
               upd_ac  = 1'b1;
            end
            AND, XOR, OR: begin
               upd_szp   = 1'b1;
               clr_logic = 1'b1;
            end
            ROTATE_LEFT, ROTATE_RIGHT, ROTATE_LEFT_CARRY, ROTATE_RIGHT_CARRY, CMC, STC: begin
               upd_cy = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_AC_EN
   logic [3:0] nib_b;
   logic [4:0] nib_res;

   // INC/DEC act on an implied operand of 1; subtract-type ops report borrow out of bit 3.
   always_comb begin
      nib_b = (op_i == INC || op_i == DEC) ? 4'd1 : b_nib_i;
      if (op_i == SUB || op_i == SUB_BORROW || op_i == DEC) begin
         nib_res = {1'b0, a_nib_i} - {1'b0, nib_b} - {4'b0000, cin_i};
      end else begin
         nib_res = {1'b0, a_nib_i} + {1'b0, nib_b} + {4'b0000, cin_i};
      end
   end
   assign ac_new = nib_res[4];
`else
   assign ac_new = 1'b0;
`endif

   always_comb begin
      flags_d = flags_q;
      if (load_i) begin
         flags_d = load_dat_i;
      end else if (commit_i) begin
         if (upd_szp) begin
            flags_d[FLG_S] = alu_flag_i[2];
            flags_d[FLG_Z] = ~alu_flag_i[3];
            flags_d[FLG_P] = alu_flag_i[1];
         end
         if (upd_cy) flags_d[FLG_CY] = alu_flag_i[0];
         if (upd_ac) flags_d[FLG_AC] = ac_new;
         if (clr_logic) begin
            flags_d[FLG_CY] = 1'b0;
            flags_d[FLG_AC] = 1'b0;
         end
      end
`ifndef ALU_SEQ_AC_EN
      flags_d[FLG_AC] = 1'b0;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) flags_q <= RST_VAL;
      else          flags_q <= flags_d;
   end

   assign flags_o = flags_q;

endmodule

// File: rtl/alu_seq.sv
// 8080 ALU sequencer: accepts one op, drives the ALU for one pass (two for DAD), returns the result.
// Optional auxiliary-carry support is enabled by defining ALU_SEQ_AC_EN.
module alu_seq
   import alu_pkg::*;
#(
   parameter logic [4:0] FLAGS_RST = 5'b00000
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   alu_seq_if.slave       bus,
   output logic [7:0]     alu_a_o,
   output logic [7:0]     alu_b_o,
   output logic [3:0]     alu_sel_o,
   output logic           alu_cin_o,
   output logic           alu_out_o,
   output logic           flag_out_o,
   input  logic [7:0]     alu_dat_i,
   input  logic [3:0]     alu_flag_i,
   output logic [4:0]     flags_o,
   input  logic           flags_we_i,
   input  logic [4:0]     flags_dat_i,
   output alu_seq_state_t dbg_state_o
);

   alu_seq_state_t state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic        dad_q, dad_d;
   logic        wb_q, wb_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [15:0] res_q, res_d;
   logic        cout_q, cout_d;
   logic        ready_raw;
   logic        commit;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      dad_d      = dad_q;
      wb_d       = wb_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      cout_d     = cout_q;
      ready_raw  = 1'b0;
      commit     = 1'b0;
      alu_a_o    = 8'h00;
      alu_b_o    = 8'h00;
      alu_sel_o  = INC;
      alu_cin_o  = 1'b0;
      alu_out_o  = 1'b0;
      flag_out_o = 1'b0;
      bus.rsp_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            ready_raw = 1'b1;
            if (bus.req_valid_i) begin
               // The effective ALU op is fixed at accept so later stages never look at the raw code.
               op_d  = bus.req_dad_i ? ADD : (bus.req_cmp_i ? SUB : bus.req_op_i);
               dad_d = bus.req_dad_i;
               wb_d  = ~(bus.req_cmp_i |
                         (~bus.req_dad_i & (bus.req_op_i == CMC || bus.req_op_i == STC)));
               a_d   = bus.req_a_i;
               b_d   = bus.req_b_i;
               state_d = EXEC_LO;
            end
         end
         EXEC_LO: begin
            alu_out_o  = 1'b1;
            flag_out_o = 1'b1;
            alu_a_o    = a_q[7:0];
            alu_b_o    = b_q[7:0];
            alu_sel_o  = op_q;
            alu_cin_o  = uses_cy(op_q) & flags_o[FLG_CY];
            res_d      = {8'h00, alu_dat_i};
            cout_d     = alu_flag_i[0];
            if (dad_q) begin
               state_d = EXEC_HI;
            end else begin
               commit  = 1'b1;
               state_d = RESP;
            end
         end
         EXEC_HI: begin
            alu_out_o  = 1'b1;
            flag_out_o = 1'b1;
            alu_a_o    = a_q[15:8];
            alu_b_o    = b_q[15:8];
            alu_sel_o  = ADD_CARRY;
            alu_cin_o  = cout_q;
            res_d      = {alu_dat_i, res_q[7:0]};
            commit     = 1'b1;
            state_d    = RESP;
         end
         RESP: begin
            bus.rsp_valid_o = 1'b1;
            if (bus.rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         op_q   <= 4'h0;
         dad_q  <= 1'b0;
         wb_q   <= 1'b0;
         a_q    <= 16'h0000;
         b_q    <= 16'h0000;
         res_q  <= 16'h0000;
         cout_q <= 1'b0;
      end else begin
         op_q   <= op_d;
         dad_q  <= dad_d;
         wb_q   <= wb_d;
         a_q    <= a_d;
         b_q    <= b_d;
         res_q  <= res_d;
         cout_q <= cout_d;
      end
   end

   // Ready is forced low while reset is held so the decoder cannot hand off into a resetting block.
   assign bus.req_ready_o = ready_raw & rst_n_i;
   assign bus.rsp_dat_o   = res_q;
   assign bus.rsp_wb_o    = wb_q;
   assign dbg_state_o     = state_q;

   alu_seq_flags #(
      .FLAGS_RST (FLAGS_RST)
   ) u_flags (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_i     (flags_we_i && state_q == IDLE),
      .load_dat_i (flags_dat_i),
      .commit_i   (commit),
      .op_i       (op_q),
      .dad_i      (dad_q),
      .alu_flag_i (alu_flag_i),
`ifdef ALU_SEQ_AC_EN
      .a_nib_i    (a_q[3:0]),
      .b_nib_i    (b_q[3:0]),
      .cin_i      (alu_cin_o),
`endif
      .flags_o    (flags_o)
   );

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; contains a behavioural 8080 ALU to close the loop.
module tb_alu_seq;
   import alu_pkg::*;

`ifdef ALU_SEQ_AC_EN
   localparam logic AC_ON = 1'b1;
`else
   localparam logic AC_ON = 1'b0;
`endif

   logic           clk;
   logic           rst_n;
   logic [7:0]     alu_a, alu_b, alu_dat;
   logic [3:0]     alu_sel, alu_flag;
   logic           alu_cin, alu_out, flag_out;
   logic [4:0]     flags, flags_dat;
   logic           flags_we;
   alu_seq_state_t dut_state;
   logic [8:0]     alu_t;

   int n_checks = 0;
   int n_fail   = 0;

   alu_seq_if bus ();

   alu_seq dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .bus         (bus.slave),
      .alu_a_o     (alu_a),
      .alu_b_o     (alu_b),
      .alu_sel_o   (alu_sel),
      .alu_cin_o   (alu_cin),
      .alu_out_o   (alu_out),
      .flag_out_o  (flag_out),
      .alu_dat_i   (alu_dat),
      .alu_flag_i  (alu_flag),
      .flags_o     (flags),
      .flags_we_i  (flags_we),
      .flags_dat_i (flags_dat),
      .dbg_state_o (dut_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Behavioural ALU: alu_t = {cout, result}
   always_comb begin
      alu_t = 9'h000;
      case (alu_sel)
         INC:                alu_t = {1'b0, alu_a} + 9'd1;
         DEC:                alu_t = {1'b0, alu_a} - 9'd1;
         ADD:                alu_t = {1'b0, alu_a} + {1'b0, alu_b};
         ADD_CARRY:          alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
         SUB:                alu_t = {1'b0, alu_a} - {1'b0, alu_b};
         SUB_BORROW:         alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
         AND:                alu_t = {1'b0, alu_a & alu_b};
         XOR:                alu_t = {1'b0, alu_a ^ alu_b};
         OR:                 alu_t = {1'b0, alu_a | alu_b};
         COMPLEMENT:         alu_t = {1'b0, ~alu_a};
         ROTATE_LEFT:        alu_t = {alu_a[7], alu_a[6:0], alu_a[7]};
         ROTATE_RIGHT:       alu_t = {alu_a[0], alu_a[0], alu_a[7:1]};
         ROTATE_LEFT_CARRY:  alu_t = {alu_a[7], alu_a[6:0], alu_cin};
         ROTATE_RIGHT_CARRY: alu_t = {alu_a[0], alu_cin, alu_a[7:1]};
         CMC:                alu_t = {~alu_cin, alu_a};
         STC:                alu_t = {1'b1, alu_a};
         default:            alu_t = 9'h000;
      endcase
   end
   assign alu_dat  = alu_t[7:0];
   assign alu_flag = {|alu_t[7:0], alu_t[7], ~^alu_t[7:0], alu_t[8]};

   // scoreboard check
   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver: present a request and return 1ns after the accepting edge (DUT in EXEC_LO)
   task automatic do_req(input logic [3:0] op, input logic dad, input logic cmp,
                         input logic [15:0] a, input logic [15:0] b, input logic ld,
                         input logic [4:0] ld_dat);
      int waited = 0;
      @(negedge clk);
      while (!bus.req_ready_o && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check_eq("req_ready_wait", 16'(bus.req_ready_o), 16'd1);
      bus.req_valid_i = 1'b1;
      bus.req_op_i    = op;
      bus.req_dad_i   = dad;
      bus.req_cmp_i   = cmp;
      bus.req_a_i     = a;
      bus.req_b_i     = b;
      flags_we        = ld;
      flags_dat       = ld_dat;
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      flags_we        = 1'b0;
   endtask

   // 8-bit op response: EXEC_LO now, RESP after next edge, IDLE after the one after
   task automatic finish_8(input string tag, input logic [15:0] dat, input logic wb,
                           input logic [4:0] fl);
      check_eq({tag, "_exec_valid"}, 16'(bus.rsp_valid_o), 16'd0);
      @(posedge clk);
      #1;
      check_eq({tag, "_valid"}, 16'(bus.rsp_valid_o), 16'd1);
      check_eq({tag, "_dat"},   bus.rsp_dat_o, dat);
      check_eq({tag, "_wb"},    16'(bus.rsp_wb_o), 16'(wb));
      check_eq({tag, "_flags"}, 16'(flags), 16'(fl));
      @(posedge clk);
      #1;
      check_eq({tag, "_idle"}, 16'(bus.req_ready_o), 16'd1);
   endtask

   task automatic load_flags(input logic [4:0] v);
      @(negedge clk);
      flags_we  = 1'b1;
      flags_dat = v;
      @(posedge clk);
      #1;
      flags_we  = 1'b0;
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.req_valid_i = 1'b0;
      bus.req_op_i    = 4'h0;
      bus.req_dad_i   = 1'b0;
      bus.req_cmp_i   = 1'b0;
      bus.req_a_i     = 16'h0000;
      bus.req_b_i     = 16'h0000;
      bus.rsp_ready_i = 1'b1;
      flags_we        = 1'b0;
      flags_dat       = 5'h00;

      #12;
      check_eq("rst_req_ready", 16'(bus.req_ready_o), 16'd0);
      check_eq("rst_rsp_valid", 16'(bus.rsp_valid_o), 16'd0);
      check_eq("rst_flags",     16'(flags), 16'h0000);
      check_eq("rst_alu_out",   16'(alu_out), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rel_req_ready", 16'(bus.req_ready_o), 16'd1);

      // ADD 3A + C6 = 0x100
      do_req(ADD, 1'b0, 1'b0, 16'h003A, 16'h00C6, 1'b0, 5'h00);
      check_eq("add_alu_out",  16'(alu_out), 16'd1);
      check_eq("add_flag_out", 16'(flag_out), 16'd1);
      finish_8("add", 16'h0000, 1'b1, {2'b01, AC_ON, 2'b11});

      // DAD 12FF + 0001 with flags preloaded to all ones
      load_flags(5'h1F);
      check_eq("load_flags", 16'(flags), 16'({2'b11, AC_ON, 2'b11}));
      do_req(INC, 1'b1, 1'b0, 16'h12FF, 16'h0001, 1'b0, 5'h00);
      check_eq("dad_lo_sel", 16'(alu_sel), 16'(ADD));
      check_eq("dad_lo_a",   16'(alu_a), 16'h00FF);
      check_eq("dad_lo_cin", 16'(alu_cin), 16'd0);
      @(posedge clk);
      #1;
      check_eq("dad_hi_sel",   16'(alu_sel), 16'(ADD_CARRY));
      check_eq("dad_hi_cin",   16'(alu_cin), 16'd1);
      check_eq("dad_hi_a",     16'(alu_a), 16'h0012);
      check_eq("dad_hi_valid", 16'(bus.rsp_valid_o), 16'd0);
      finish_8("dad", 16'h1300, 1'b1, {2'b11, AC_ON, 2'b10});

      // STC then ADC 01 + 01
      do_req(STC, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'h00);
      finish_8("stc", 16'h0000, 1'b0, {2'b11, AC_ON, 2'b11});
      do_req(ADD_CARRY, 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0, 5'h00);
      check_eq("adc_cin", 16'(alu_cin), 16'd1);
      finish_8("adc", 16'h0003, 1'b1, 5'b00010);

      // Compare 05 vs 05; req_op is ignored
      do_req(AND, 1'b0, 1'b1, 16'h0005, 16'h0005, 1'b0, 5'h00);
      check_eq("cmp_sel", 16'(alu_sel), 16'(SUB));
      finish_8("cmp", 16'h0000, 1'b0, 5'b01010);

      // Flag load in the accepting cycle is seen by the op: ADC 10 + 20 + CY
      do_req(ADD_CARRY, 1'b0, 1'b0, 16'h0010, 16'h0020, 1'b1, 5'h01);
      finish_8("adc_ld", 16'h0031, 1'b1, 5'b00000);

      // INC keeps CY
      do_req(STC, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 5'h00);
      finish_8("stc2", 16'h0000, 1'b0, 5'b00001);
      do_req(INC, 1'b0, 1'b0, 16'h00FF, 16'h0000, 1'b0, 5'h00);
      finish_8("inc", 16'h0000, 1'b1, {2'b01, AC_ON, 2'b11});

      // AND clears CY and AC; COMPLEMENT leaves flags; RAR takes CY from bit 0
      do_req(AND, 1'b0, 1'b0, 16'h00F0, 16'h003C, 1'b0, 5'h00);
      finish_8("and", 16'h0030, 1'b1, 5'b00010);
      do_req(COMPLEMENT, 1'b0, 1'b0, 16'h005A, 16'h0000, 1'b0, 5'h00);
      finish_8("cma", 16'h00A5, 1'b1, 5'b00010);
      do_req(ROTATE_RIGHT_CARRY, 1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, 5'h00);
      finish_8("rar", 16'h0000, 1'b1, 5'b00011);

      // Backpressure: response held for 5 cycles; flag load while busy is ignored
      bus.rsp_ready_i = 1'b0;
      do_req(ADD, 1'b0, 1'b0, 16'h0012, 16'h0034, 1'b0, 5'h00);
      @(posedge clk);
      #1;
      flags_we  = 1'b1;
      flags_dat = 5'h1F;
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_valid", 16'(bus.rsp_valid_o), 16'd1);
         check_eq("bp_dat",   bus.rsp_dat_o, 16'h0046);
         check_eq("bp_ready", 16'(bus.req_ready_o), 16'd0);
         check_eq("bp_flags", 16'(flags), 16'h0000);
         @(posedge clk);
         #1;
      end
      flags_we = 1'b0;
      bus.rsp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      check_eq("bp_done_valid", 16'(bus.rsp_valid_o), 16'd0);
      check_eq("bp_done_ready", 16'(bus.req_ready_o), 16'd1);
      check_eq("bp_done_flags", 16'(flags), 16'h0000);

      // Nibble carry: ADD 0F + 01
      do_req(ADD, 1'b0, 1'b0, 16'h000F, 16'h0001, 1'b0, 5'h00);
      finish_8("ac", 16'h0010, 1'b1, {2'b00, AC_ON, 2'b00});

      // Reset while in EXEC_HI
      do_req(ADD, 1'b1, 1'b0, 16'h00FF, 16'h0001, 1'b0, 5'h00);
      @(posedge clk);
      #1;
      check_eq("pre_rst_state", 16'(dut_state), 16'(EXEC_HI));
      check_eq("pre_rst_cin",   16'(alu_cin), 16'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_alu_out",  16'(alu_out), 16'd0);
      check_eq("mid_rst_flag_out", 16'(flag_out), 16'd0);
      check_eq("mid_rst_cin",      16'(alu_cin), 16'd0);
      check_eq("mid_rst_sel",      16'(alu_sel), 16'd0);
      check_eq("mid_rst_a",        16'(alu_a), 16'd0);
      check_eq("mid_rst_ready",    16'(bus.req_ready_o), 16'd0);
      check_eq("mid_rst_valid",    16'(bus.rsp_valid_o), 16'd0);
      check_eq("mid_rst_dat",      bus.rsp_dat_o, 16'h0000);
      check_eq("mid_rst_wb",       16'(bus.rsp_wb_o), 16'd0);
      check_eq("mid_rst_flags",    16'(flags), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("post_rst_state", 16'(dut_state), 16'(IDLE));
      check_eq("post_rst_ready", 16'(bus.req_ready_o), 16'd1);

      do_req(ADD, 1'b0, 1'b0, 16'h003A, 16'h00C6, 1'b0, 5'h00);
      finish_8("add2", 16'h0000, 1'b1, {2'b01, AC_ON, 2'b11});

      // report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
